// File: rtl/tri_stream_collector.sv
// Groups the incoming vertex stream into triangles and queues them for the rasterizer.
// Handles overflow when the FIFO is full and frames that end on a partial triangle.
module tri_stream_collector #(
  parameter int DEPTH   = 8,
  parameter int COORD_W = 32,
  parameter int COLOR_W = 24,
  parameter int CNT_W   = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   valid_in,
  input  logic [COORD_W-1:0]     vertex_x,
  input  logic [COORD_W-1:0]     vertex_y,
  input  logic [COORD_W-1:0]     vertex_z,
  input  logic [COLOR_W-1:0]     color_in,
  input  logic                   last_in,
  output logic                   tri_valid_out,
  input  logic                   tri_ready_in,
  output logic [3*COORD_W-1:0]   tri_x_out,
  output logic [3*COORD_W-1:0]   tri_y_out,
  output logic [3*COORD_W-1:0]   tri_z_out,
  output logic [COLOR_W-1:0]     tri_color_out,
  output logic                   tri_last_out,
  output logic [$clog2(DEPTH):0] fill_out,
  output logic                   frame_done_out,
  output logic [CNT_W-1:0]       tri_count_out,
  output logic                   overflow_out,
  output logic                   malformed_out
);

  // state | meaning
  // S_V0  | waiting for vertex 0 of a triangle
  // S_V1  | vertex 0 staged, waiting for vertex 1
  // S_V2  | vertices 0 and 1 staged, next vertex completes the triangle
  typedef enum logic [1:0] {S_V0, S_V1, S_V2} idx_e;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH) + 1;
  localparam int TW = 3 * COORD_W;

  idx_e idx_q, idx_d;

  logic [COORD_W-1:0] x0_q, y0_q, z0_q, x1_q, y1_q, z1_q;
  logic [COLOR_W-1:0] c0_q;

  logic [TW-1:0]      x_mem [DEPTH];
  logic [TW-1:0]      y_mem [DEPTH];
  logic [TW-1:0]      z_mem [DEPTH];
  logic [COLOR_W-1:0] c_mem [DEPTH];
  logic               l_mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] tri_count_q, tri_count_d;
  logic             done_q, ovf_q, mal_q;

  logic push_req, push_ok, pop, full, eof;

  always_ff @(posedge clk_in) begin
    if (rst_in) idx_q <= S_V0;
    else        idx_q <= idx_d;
  end

  always_comb begin
    idx_d    = idx_q;
    push_req = 1'b0;
    if (valid_in) begin
      case (idx_q)
        S_V0:    idx_d = S_V1;
        S_V1:    idx_d = S_V2;
        S_V2: begin
          idx_d    = S_V0;
          push_req = 1'b1;
        end
        default: idx_d = S_V0;
      endcase
      // An early last abandons whatever is staged.
      if (last_in) idx_d = S_V0;
    end
  end

  assign full    = (fill_q == FW'(DEPTH));
  assign pop     = tri_valid_out && tri_ready_in;
  assign push_ok = push_req && (!full || pop);
  assign eof     = valid_in && last_in;
  assign cnt_inc = (push_ok && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_comb begin
    fill_d = fill_q;
    case ({push_ok, pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
    cnt_d       = eof ? '0 : cnt_inc;
    tri_count_d = eof ? cnt_inc : tri_count_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x0_q <= '0; y0_q <= '0; z0_q <= '0;
      x1_q <= '0; y1_q <= '0; z1_q <= '0;
      c0_q <= '0;
    end else if (valid_in && idx_q == S_V0) begin
      x0_q <= vertex_x; y0_q <= vertex_y; z0_q <= vertex_z;
      c0_q <= color_in;
    end else if (valid_in && idx_q == S_V1) begin
      x1_q <= vertex_x; y1_q <= vertex_y; z1_q <= vertex_z;
    end
  end

  // Storage array is not reset; the head fields are masked while empty.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      x_mem[wr_ptr_q] <= {vertex_x, x1_q, x0_q};
      y_mem[wr_ptr_q] <= {vertex_y, y1_q, y0_q};
      z_mem[wr_ptr_q] <= {vertex_z, z1_q, z0_q};
      c_mem[wr_ptr_q] <= c0_q;
      l_mem[wr_ptr_q] <= last_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      tri_count_q <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      mal_q       <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      tri_count_q <= tri_count_d;
      done_q      <= eof;
      if (push_req && !push_ok)            ovf_q <= 1'b1;
      if (eof && idx_q != S_V2)            mal_q <= 1'b1;
    end
  end

  assign tri_valid_out  = (fill_q != '0);
  assign tri_x_out      = tri_valid_out ? x_mem[rd_ptr_q] : '0;
  assign tri_y_out      = tri_valid_out ? y_mem[rd_ptr_q] : '0;
  assign tri_z_out      = tri_valid_out ? z_mem[rd_ptr_q] : '0;
  assign tri_color_out  = tri_valid_out ? c_mem[rd_ptr_q] : '0;
  assign tri_last_out   = tri_valid_out ? l_mem[rd_ptr_q] : 1'b0;
  assign fill_out       = fill_q;
  assign frame_done_out = done_q;
  assign tri_count_out  = tri_count_q;
  assign overflow_out   = ovf_q;
  assign malformed_out  = mal_q;

endmodule

// File: tb/tb_tri_stream_collector.sv
// Randomized and directed bench for tri_stream_collector against a queue-based
// model of vertex grouping, triangle FIFO and frame bookkeeping.
module tb_tri_stream_collector;

  localparam int DEPTH = 8;
  localparam int CW    = 32;
  localparam int KW    = 24;
  localparam int NW    = 16;

  logic            clk = 1'b0;
  logic            rst, valid, last, ready;
  logic [CW-1:0]   vx, vy, vz;
  logic [KW-1:0]   vc;
  logic            tri_valid, tri_last, frame_done, ovf, mal;
  logic [3*CW-1:0] tx, ty, tz;
  logic [KW-1:0]   tc;
  logic [3:0]      fill;
  logic [NW-1:0]   tcount;

  int vectors = 0;
  int miscompares = 0;

  tri_stream_collector #(.DEPTH(DEPTH), .COORD_W(CW), .COLOR_W(KW), .CNT_W(NW)) dut (
    .clk_in(clk), .rst_in(rst), .valid_in(valid),
    .vertex_x(vx), .vertex_y(vy), .vertex_z(vz), .color_in(vc), .last_in(last),
    .tri_valid_out(tri_valid), .tri_ready_in(ready),
    .tri_x_out(tx), .tri_y_out(ty), .tri_z_out(tz), .tri_color_out(tc),
    .tri_last_out(tri_last), .fill_out(fill), .frame_done_out(frame_done),
    .tri_count_out(tcount), .overflow_out(ovf), .malformed_out(mal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] x, y, z;
    logic [KW-1:0] c;
  } vtx_t;

  typedef struct {
    logic [3*CW-1:0] x, y, z;
    logic [KW-1:0]   c;
    logic            last;
  } tri_t;

  vtx_t pend[$];
  tri_t fq[$];
  int   m_cnt, m_tcount;
  bit   m_done, m_ovf, m_mal;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit   popped;
    bit   ok;
    vtx_t v;
    tri_t t;
    if (rst) begin
      pend.delete(); fq.delete();
      m_cnt = 0; m_tcount = 0; m_done = 0; m_ovf = 0; m_mal = 0;
      return;
    end
    popped = (fq.size() != 0) && ready;
    m_done = 0;
    if (valid) begin
      v.x = vx; v.y = vy; v.z = vz; v.c = vc;
      if (pend.size() == 2) begin
        t.x = {v.x, pend[1].x, pend[0].x};
        t.y = {v.y, pend[1].y, pend[0].y};
        t.z = {v.z, pend[1].z, pend[0].z};
        t.c = pend[0].c;
        t.last = last;
        ok = (fq.size() < DEPTH) || popped;
        if (popped) begin void'(fq.pop_front()); popped = 0; end
        if (ok) begin
          fq.push_back(t);
          if (m_cnt < (1 << NW) - 1) m_cnt++;
        end else m_ovf = 1;
        pend.delete();
        if (last) begin m_tcount = m_cnt; m_cnt = 0; m_done = 1; end
      end else if (last) begin
        pend.delete();
        m_mal = 1; m_tcount = m_cnt; m_cnt = 0; m_done = 1;
      end else pend.push_back(v);
    end
    if (popped) void'(fq.pop_front());
  endtask

  task automatic check_all();
    chk_eq("tri_valid", tri_valid, fq.size() != 0);
    chk_eq("fill", fill, fq.size());
    chk_eq("frame_done", frame_done, m_done);
    chk_eq("tri_count", tcount, m_tcount);
    chk_eq("overflow", ovf, m_ovf);
    chk_eq("malformed", mal, m_mal);
    if (fq.size() != 0) begin
      chk_eq("head_x", tx, fq[0].x);
      chk_eq("head_y", ty, fq[0].y);
      chk_eq("head_z", tz, fq[0].z);
      chk_eq("head_color", tc, fq[0].c);
      chk_eq("head_last", tri_last, fq[0].last);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [CW-1:0] x, input logic [CW-1:0] y,
                      input logic [CW-1:0] z, input logic [KW-1:0] c, input bit l, input bit rd);
    rst = r; valid = v; vx = x; vy = y; vz = z; vc = c; last = l; ready = rd;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic rvtx(input bit l, input bit rd);
    step(1'b0, 1'b1, $urandom, $urandom, $urandom, KW'($urandom), l, rd);
  endtask

  task automatic idle(input bit rd);
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, rd);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1; valid = 0; last = 0; ready = 0; vx = 0; vy = 0; vz = 0; vc = 0;
    @(negedge clk);
    do_reset();
    chk_eq("reset_x", tx, 0);
    chk_eq("reset_color", tc, 0);
    chk_eq("reset_last", tri_last, 0);

    // Basic triangle
    step(0, 1, 5, 4, 1, 24'hFF0000, 0, 1);
    step(0, 1, 7, 4, 2, 24'h00FF00, 0, 1);
    step(0, 1, 14, 6, 3, 24'h0000FF, 1, 1);
    chk_eq("basic_valid", tri_valid, 1);
    chk_eq("basic_x", tx, {32'd14, 32'd7, 32'd5});
    chk_eq("basic_color", tc, 24'hFF0000);
    chk_eq("basic_last", tri_last, 1);
    chk_eq("basic_done", frame_done, 1);
    chk_eq("basic_count", tcount, 1);
    idle(1);
    chk_eq("basic_done_once", frame_done, 0);

    // Backpressure: 4 triangles held, then drained
    for (int i = 0; i < 12; i++) rvtx(i == 11, 0);
    chk_eq("bp_fill", fill, 4);
    for (int i = 0; i < 3; i++) idle(0);
    for (int i = 0; i < 4; i++) idle(1);
    chk_eq("bp_drained", fill, 0);

    // Overflow: 9 triangles into an 8-deep FIFO
    for (int i = 0; i < 27; i++) rvtx(i == 26, 0);
    chk_eq("ovf_flag", ovf, 1);
    chk_eq("ovf_fill", fill, 8);
    chk_eq("ovf_count", tcount, 8);
    for (int i = 0; i < 8; i++) idle(1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 26; i++) rvtx(0, 0);
    chk_eq("full_fill", fill, 8);
    rvtx(0, 1);
    chk_eq("full_pp_fill", fill, 8);
    chk_eq("full_pp_ovf", ovf, 0);

    // Malformed frame then a clean triangle
    do_reset();
    for (int i = 0; i < 5; i++) rvtx(i == 4, 1);
    chk_eq("mal_flag", mal, 1);
    chk_eq("mal_count", tcount, 1);
    for (int i = 0; i < 3; i++) rvtx(i == 2, 0);
    chk_eq("mal_next_fill", fill, 1);
    for (int i = 0; i < 2; i++) idle(1);

    // Reset mid-frame
    for (int i = 0; i < 11; i++) rvtx(0, 0);
    do_reset();
    chk_eq("rst_fill", fill, 0);
    chk_eq("rst_valid", tri_valid, 0);
    chk_eq("rst_ovf", ovf, 0);
    chk_eq("rst_mal", mal, 0);
    for (int i = 0; i < 3; i++) rvtx(0, 0);
    chk_eq("rst_next_fill", fill, 1);

    // Randomized traffic with varying rasterizer throughput
    for (int ph = 0; ph < 8; ph++) begin
      int rdy_pct;
      rdy_pct = (ph % 4 == 0) ? 10 : (ph % 4 == 1) ? 50 : (ph % 4 == 2) ? 90 : 100;
      if (ph == 4) do_reset();
      for (int i = 0; i < 400; i++) begin
        bit v, l, rd;
        v  = ($urandom_range(99) < 70);
        l  = ($urandom_range(99) < 8);
        rd = ($urandom_range(99) < rdy_pct);
        if (v) rvtx(l, rd);
        else   idle(rd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tri_stream_collector.md
Name: tri_stream_collector

Overview:
- Consumer end of the triangle-generator vertex stream: takes one vertex per valid cycle (x, y, z, color, last) and groups every three consecutive vertices into one triangle.
- Buffers completed triangles in a small FIFO and presents them to the rasterizer over a valid/ready handshake.
- The generator has no backpressure, so this block absorbs bursts, reports overflow, and reports malformed frames.

Parameters:
- DEPTH, 8, triangle FIFO depth in entries; power of two, at least 2.
- COORD_W, 32, width of each vertex coordinate.
- COLOR_W, 24, width of the vertex color.
- CNT_W, 16, width of the per-frame triangle counter.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- valid_in  input  1  vertex fields valid this cycle.
- vertex_x  input  COORD_W  vertex x.
- vertex_y  input  COORD_W  vertex y.
- vertex_z  input  COORD_W  vertex z.
- color_in  input  COLOR_W  vertex color.
- last_in  input  1  final vertex of the frame.
- tri_valid_out  output  1  FIFO head holds a triangle.
- tri_ready_in  input  1  rasterizer accepts the head entry.
- tri_x_out  output  3*COORD_W  {v2,v1,v0} x coordinates, v0 in the LSBs.
- tri_y_out  output  3*COORD_W  {v2,v1,v0} y coordinates.
- tri_z_out  output  3*COORD_W  {v2,v1,v0} z coordinates.
- tri_color_out  output  COLOR_W  color of v0.
- tri_last_out  output  1  head entry is the last triangle of its frame.
- fill_out  output  clog2(DEPTH)+1  FIFO occupancy.
- frame_done_out  output  1  one-cycle pulse at end of frame.
- tri_count_out  output  CNT_W  triangles pushed in the last completed frame.
- overflow_out  output  1  sticky: a triangle was dropped because the FIFO was full.
- malformed_out  output  1  sticky: last_in arrived with a partial triangle.

Behaviour:
- Clock and reset: single clock clk_in; reset rst_in is synchronous and active-high.
- Reset values: all outputs 0; vertex index 0; staging registers 0; FIFO empty; frame counter 0.
- Reset mid-frame discards any partial triangle, all FIFO contents and both sticky flags.
- Vertex index: idx cycles 0→1→2→0 and advances only on valid_in.
  - idx 0 or 1: capture the vertex into staging slot idx; the color is captured only at idx 0.
  - idx 2: form the triangle {staging v0, staging v1, incoming v2} with last = last_in, and request a push.
- Push rules:
  - Push succeeds if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the triangle is dropped and overflow_out is set (sticky until reset).
- Frame counter:
  - Increments on each successful push.
  - Dropped triangles are not counted.
  - Saturates at 2^CNT_W−1.
- End of frame: on valid_in with last_in=1 and idx=2, regardless of whether the push succeeds:
  - tri_count_out ← counter + (push succeeded ? 1 : 0);
  - counter ← 0;
  - frame_done_out pulses high on the next cycle for exactly one cycle.
- Malformed frame: on valid_in with last_in=1 and idx≠2:
  - the partial triangle is discarded and idx ← 0;
  - malformed_out is set (sticky);
  - tri_count_out ← counter, counter ← 0, and frame_done_out pulses as above.
- Latency: a triangle whose v2 is accepted in cycle N is visible at the FIFO head (tri_valid_out=1) in cycle N+1, provided the FIFO was empty.
- Output handshake:
  - tri_valid_out = (fill ≠ 0).
  - Pop occurs when tri_valid_out && tri_ready_in.
  - All head fields are stable while tri_valid_out=1 and tri_ready_in=0.
  - tri_ready_in is ignored while the FIFO is empty.
- FIFO: circular buffer with wrap-around read and write pointers.
  - Simultaneous push and pop leaves fill unchanged, including when fill is 0 or DEPTH.
  - fill_out is never greater than DEPTH.
- Width rules: coordinates and color pass through unmodified; no arithmetic is performed on vertex data.

Test Plan:
- Basic triangle: three valid_in beats with x=5,7,14, y=4,4,6, z=1,2,3, color=24'hFF0000, last on beat 3, tri_ready_in=1 → tri_valid_out=1 one cycle after beat 3; tri_x_out={14,7,5}; tri_color_out=FF0000; tri_last_out=1; frame_done_out pulses once; tri_count_out=1.
- Backpressure: 4 triangles pushed with tri_ready_in=0 → fill_out=4 and the head is held stable; raise tri_ready_in → triangles drain in order over 4 cycles; fill_out reaches 0.
- Overflow: DEPTH=8, ready=0, 9 triangles pushed, last on the 9th → overflow_out=1; fill_out=8; tri_count_out=8; the 9th triangle is absent from the drained data.
- Full with simultaneous push and pop: FIFO full, ready=1 in the cycle the 3rd vertex arrives → no drop; overflow_out stays 0; fill_out stays 8.
- Malformed frame: 5 vertices with last on the 5th → malformed_out=1; tri_count_out=1; the next frame starts at idx 0 and is assembled correctly.
- Reset mid-frame: assert rst_in after 2 vertices with 3 triangles queued → fill_out=0, tri_valid_out=0, sticky flags clear; the next 3 vertices form a correct triangle.
